uart_rx: RTL and testbench

Serial UART receiver: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous serial line and presents each byte as a parallel word with a one-cycle valid strobe. It is the receive end of the board UART link and sits between the external RX pin and downstream byte consumers, such as command parsers or the EEPROM write path. The bit period equals that of the transmit side, so both ends share one baud setting.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 3-flop input synchronizer, mid-bit sampling, one-cycle
// strobes for a good byte (dout_vld) or a low stop bit (frame_err).
//
// state | meaning
// IDLE  | line idle, counters held at 0, waiting for a falling edge
// START | qualifying the start bit; high at mid-bit means glitch
// DATA  | sampling data bits 1..8 at mid-bit, LSB first
// STOP  | sampling the stop bit, back to IDLE at its midpoint
module uart_rx #(
    parameter int BAUD = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [12:0] BPS_LAST = 13'(BAUD - 1);
    localparam logic [12:0] BPS_MID  = 13'(BAUD / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        din_r0;
    logic        din_r1;
    logic        din_r2;
    logic        fall;
    logic [12:0] cnt_bps;
    logic [3:0]  cnt_bit;
    logic [7:0]  shift_reg;
    logic        sample_pt;
    logic        bps_wrap;
    logic        shift_en;
    logic        load_byte;
    logic        stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_r0 <= 1'b1;
            din_r1 <= 1'b1;
            din_r2 <= 1'b1;
        end else begin
            din_r0 <= din;
            din_r1 <= din_r0;
            din_r2 <= din_r1;
        end
    end

    assign fall      = din_r2 & ~din_r1;
    assign sample_pt = (cnt_bps == BPS_MID);
    assign bps_wrap  = (cnt_bps == BPS_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (sample_pt && din_r1) begin
                    state_nxt = IDLE;
                end else if (bps_wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_en = 1'b1;
                end
                if (bps_wrap && (cnt_bit == 4'd8)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start bit right behind it is caught.
                if (sample_pt) begin
                    state_nxt = IDLE;
                    if (din_r1) begin
                        load_byte = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bps <= 13'd0;
            cnt_bit <= 4'd0;
        end else if ((state == IDLE) || (state_nxt == IDLE)) begin
            cnt_bps <= 13'd0;
            cnt_bit <= 4'd0;
        end else if (bps_wrap) begin
            cnt_bps <= 13'd0;
            cnt_bit <= cnt_bit + 4'd1;
        end else begin
            cnt_bps <= cnt_bps + 13'd1;
        end
    end

    // Right shift: after eight samples the first data bit sits in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if (shift_en) begin
            shift_reg <= {din_r1, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= 8'h00;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dout_vld  <= load_byte;
            frame_err <= stop_bad;
            if (load_byte) begin
                dout <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD = 16: table of serial frames with a scoreboard of
// expected strobes, plus hand-written glitch and mid-frame reset sequences.
module tb_uart_rx;

    localparam int BAUD    = 16;
    localparam int LAT_EXP = 9 * BAUD + BAUD / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic [7:0] dout;
    logic       dout_vld;
    logic       frame_err;
    logic       busy;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         per;
        logic       stop_lvl;
        int         lead;
        logic       tail_lvl;
        int         tail;
        logic       exp_err;
        logic [7:0] exp_dout;
    } frame_t;

    typedef struct {
        logic       is_err;
        logic [7:0] dout;
    } exp_t;

    frame_t vec[8];
    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     rd_ptr = 0;

    // Monitor: logs every strobe with its cycle offset from busy rising.
    int         cyc = 0;
    logic       busy_q = 1'b0;
    int         rise_cyc = 0;
    int         busy_len = 0;
    int         last_busy_len = 0;
    int         obs_cnt = 0;
    logic       obs_err[64];
    logic [7:0] obs_dout[64];
    int         obs_lat[64];
    logic       obs_both[64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        busy_q <= busy;
        if (busy && !busy_q) rise_cyc <= cyc;
        if (busy) begin
            busy_len <= busy_len + 1;
        end else if (busy_q) begin
            last_busy_len <= busy_len;
            busy_len <= 0;
        end
        if ((dout_vld || frame_err) && obs_cnt < 64) begin
            obs_err[obs_cnt]  <= frame_err;
            obs_dout[obs_cnt] <= dout;
            obs_lat[obs_cnt]  <= cyc - rise_cyc;
            obs_both[obs_cnt] <= dout_vld & frame_err;
            obs_cnt <= obs_cnt + 1;
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_level(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_lvl);
        drive_level(1'b0, per);
        for (int i = 0; i < 8; i++) drive_level(b[i], per);
        drive_level(stop_lvl, per);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   waited;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            waited = 0;
            while (rd_ptr >= obs_cnt && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (rd_ptr >= obs_cnt) begin
                errors++;
                $display("FAIL %s timeout: no strobe seen, expected err=%0b dout=0x%02h", tag, e.is_err, e.dout);
            end else begin
                check_val({tag, " kind"}, int'(obs_err[rd_ptr]), int'(e.is_err));
                check_val({tag, " dout"}, int'(obs_dout[rd_ptr]), int'(e.dout));
                check_val({tag, " latency"}, obs_lat[rd_ptr], LAT_EXP);
                check_val({tag, " exclusive"}, int'(obs_both[rd_ptr]), 0);
                rd_ptr++;
            end
        end
        repeat (2) @(negedge clk);
        check_val({tag, " extra strobes"}, obs_cnt - rd_ptr, 0);
        rd_ptr = obs_cnt;
    endtask

    initial begin
        vec[0] = '{8'h55, 16, 1'b1,  0, 1'b1, 20, 1'b0, 8'h55};
        vec[1] = '{8'hA3, 16, 1'b1,  0, 1'b1,  0, 1'b0, 8'hA3};
        vec[2] = '{8'h00, 16, 1'b1,  0, 1'b1, 20, 1'b0, 8'h00};
        vec[3] = '{8'h3C, 16, 1'b1,  0, 1'b1, 20, 1'b0, 8'h3C};
        vec[4] = '{8'hFF, 16, 1'b0,  0, 1'b0, 40, 1'b1, 8'h3C};
        vec[5] = '{8'h12, 16, 1'b1, 20, 1'b1, 20, 1'b0, 8'h12};
        vec[6] = '{8'hC7, 15, 1'b1,  0, 1'b1, 20, 1'b0, 8'hC7};
        vec[7] = '{8'hC7, 17, 1'b1,  0, 1'b1, 20, 1'b0, 8'hC7};

        repeat (3) @(negedge clk);
        check_val("reset dout", int'(dout), 8'h00);
        check_val("reset dout_vld", int'(dout_vld), 0);
        check_val("reset frame_err", int'(frame_err), 0);
        check_val("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        drive_level(1'b1, 10);

        for (int i = 0; i < 8; i++) begin
            drive_level(1'b1, vec[i].lead);
            send_frame(vec[i].data, vec[i].per, vec[i].stop_lvl);
            exp_q.push_back('{vec[i].exp_err, vec[i].exp_dout});
            drive_level(vec[i].tail_lvl, vec[i].tail);
            if (!vec[i].tail_lvl) check_val("break holds idle", int'(busy), 0);
        end
        drain("frames");

        // Start glitch: 4 low cycles must be rejected at the start-bit midpoint.
        drive_level(1'b0, 4);
        drive_level(1'b1, 40);
        check_val("glitch busy length", last_busy_len, BAUD / 2);
        check_val("glitch strobes", obs_cnt - rd_ptr, 0);
        check_val("glitch dout held", int'(dout), 8'hC7);

        // Reset during data bit 4 of 0x5A (that bit is high), then a clean 0x81.
        drive_level(1'b0, BAUD);
        for (int i = 0; i < 4; i++) drive_level(((8'h5A >> i) & 8'h01) != 0, BAUD);
        drive_level(1'b1, BAUD / 2);
        rst_n = 1'b0;
        #1;
        check_val("midreset dout", int'(dout), 8'h00);
        check_val("midreset dout_vld", int'(dout_vld), 0);
        check_val("midreset frame_err", int'(frame_err), 0);
        check_val("midreset busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        drive_level(1'b1, 30);
        check_val("post reset idle", int'(busy), 0);
        send_frame(8'h81, BAUD, 1'b1);
        exp_q.push_back('{1'b0, 8'h81});
        drive_level(1'b1, 20);
        drain("after reset");
        check_val("final dout", int'(dout), 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
